// File: rtl/hack_memory.sv
// Hack CPU data memory: 16K RAM, 8K screen region with shadow readback,
// keyboard register, and a first-word-fall-through FIFO of screen writes.
module hack_memory #(
   parameter int RAM_AW     = 14,
   parameter int SCR_AW     = 13,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [14:0]                   addressM,
   input  logic [15:0]                   outM,
   input  logic                          writeM,
   output logic [15:0]                   inM,
   output logic                          scr_valid,
   output logic [SCR_AW-1:0]             scr_addr,
   output logic [15:0]                   scr_data,
   input  logic                          scr_ready,
   input  logic [15:0]                   kbd_code,
   input  logic                          kbd_strobe,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LW = $clog2(FIFO_DEPTH);
   localparam logic [LW-1:0] PTR_ONE = LW'(1);
   localparam logic [LW:0]   LVL_ONE = (LW + 1)'(1);
   localparam logic [LW:0]   LVL_FULL = (LW + 1)'(FIFO_DEPTH);

   logic [15:0]       ram        [2**RAM_AW];
   logic [15:0]       shadow     [2**SCR_AW];
   logic [SCR_AW-1:0] fifo_addr  [FIFO_DEPTH];
   logic [15:0]       fifo_data  [FIFO_DEPTH];

   logic [LW-1:0] wr_ptr;
   logic [LW-1:0] rd_ptr;
   logic [LW:0]   level;
   logic [15:0]   kbd_reg;

   logic              is_ram;
   logic              is_scr;
   logic              is_kbd;
   logic [SCR_AW-1:0] scr_off;
   logic              scr_we;
   logic              fifo_full;
   logic              pop;
   logic              push;
   logic              drop;

   // The screen base 16384 has no bits below bit 14, so the low offset bits
   // are simply the low address bits.
   assign is_ram  = ~addressM[14];
   assign is_scr  = (addressM[14:13] == 2'b10);
   assign is_kbd  = (addressM == 15'd24576);
   assign scr_off = addressM[SCR_AW-1:0];

   assign scr_we    = writeM && is_scr;
   assign fifo_full = (level == LVL_FULL);
   assign pop       = (level != '0) && scr_ready;
   assign push      = scr_we && (!fifo_full || pop);
   assign drop      = scr_we && !push;

   always_comb begin
      inM = 16'd0;
      if (is_ram)
         inM = ram[addressM[RAM_AW-1:0]];
      else if (is_scr)
         inM = shadow[scr_off];
      else if (is_kbd)
         inM = kbd_reg;
   end

   // Storage arrays are never cleared by reset.
   always_ff @(posedge clk) begin
      if (writeM && is_ram)
         ram[addressM[RAM_AW-1:0]] <= outM;
      if (scr_we)
         shadow[scr_off] <= outM;
   end

   always_ff @(posedge clk) begin
      if (reset && push) begin
         fifo_addr[wr_ptr] <= scr_off;
         fifo_data[wr_ptr] <= outM;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         kbd_reg  <= 16'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
         if (drop)
            overflow <= 1'b1;
         if (kbd_strobe)
            kbd_reg <= kbd_code;
      end
   end

   assign scr_valid  = (level != '0);
   assign scr_addr   = fifo_addr[rd_ptr];
   assign scr_data   = fifo_data[rd_ptr];
   assign fifo_level = level;

endmodule

// File: tb/tb_hack_memory.sv
// Directed self-checking bench for hack_memory: decode, screen FIFO,
// overflow, keyboard register and reset behaviour.
module tb_hack_memory;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [14:0] addressM = 15'd0;
   logic [15:0] outM = 16'd0;
   logic        writeM = 1'b0;
   logic [15:0] inM;
   logic        scr_valid;
   logic [12:0] scr_addr;
   logic [15:0] scr_data;
   logic        scr_ready = 1'b0;
   logic [15:0] kbd_code = 16'd0;
   logic        kbd_strobe = 1'b0;
   logic        overflow;
   logic [4:0]  fifo_level;

   int compared = 0;
   int mismatched = 0;

   hack_memory dut (
      .clk        (clk),
      .reset      (reset),
      .addressM   (addressM),
      .outM       (outM),
      .writeM     (writeM),
      .inM        (inM),
      .scr_valid  (scr_valid),
      .scr_addr   (scr_addr),
      .scr_data   (scr_data),
      .scr_ready  (scr_ready),
      .kbd_code   (kbd_code),
      .kbd_strobe (kbd_strobe),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One CPU cycle: present address/data/write, then let the edge happen.
   task automatic applyStimulus(input logic [14:0] a, input logic [15:0] d, input logic w);
      addressM = a;
      outM     = d;
      writeM   = w;
      tick();
      writeM   = 1'b0;
   endtask

   task automatic readCheck(input string tag, input logic [14:0] a, input logic [15:0] exp);
      addressM = a;
      writeM   = 1'b0;
      #1;
      checkOutput(tag, {16'd0, inM}, {16'd0, exp});
   endtask

   initial begin
      // Reset
      reset = 1'b0;
      addressM = 15'd24576;
      tick();
      tick();
      checkOutput("rst_valid", {31'd0, scr_valid}, 32'd0);
      checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
      checkOutput("rst_level", {27'd0, fifo_level}, 32'd0);
      readCheck("rst_kbd", 15'd24576, 16'd0);
      reset = 1'b1;

      // RAM and reserved space
      applyStimulus(15'd1000, 16'd12345, 1'b1);
      readCheck("ram_1000", 15'd1000, 16'd12345);
      applyStimulus(15'd16383, 16'hFFFF, 1'b1);
      readCheck("ram_16383", 15'd16383, 16'hFFFF);
      applyStimulus(15'd24577, 16'd7, 1'b1);
      readCheck("reserved_read", 15'd24577, 16'd0);

      // Screen write and handshake
      scr_ready = 1'b0;
      applyStimulus(15'd16384, 16'h00FF, 1'b1);
      checkOutput("scr_valid1", {31'd0, scr_valid}, 32'd1);
      checkOutput("scr_addr0", {19'd0, scr_addr}, 32'd0);
      checkOutput("scr_data0", {16'd0, scr_data}, 32'h00FF);
      checkOutput("scr_level1", {27'd0, fifo_level}, 32'd1);
      readCheck("shadow_16384", 15'd16384, 16'h00FF);
      scr_ready = 1'b1;
      tick();
      scr_ready = 1'b0;
      checkOutput("pop_valid0", {31'd0, scr_valid}, 32'd0);
      checkOutput("pop_level0", {27'd0, fifo_level}, 32'd0);

      // Overflow: 17 writes into a 16-deep FIFO
      for (int i = 0; i < 17; i++)
         applyStimulus(15'(16384 + i), 16'(i), 1'b1);
      checkOutput("ovf_level16", {27'd0, fifo_level}, 32'd16);
      checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
      readCheck("ovf_shadow16", 15'd16400, 16'd16);
      scr_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("drain_valid_%0d", i), {31'd0, scr_valid}, 32'd1);
         checkOutput($sformatf("drain_data_%0d", i), {16'd0, scr_data}, 32'(i));
         checkOutput($sformatf("drain_addr_%0d", i), {19'd0, scr_addr}, 32'(i));
         tick();
      end
      checkOutput("drain_empty", {31'd0, scr_valid}, 32'd0);
      scr_ready = 1'b0;

      // Full FIFO with simultaneous push and pop
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checkOutput("rst2_overflow", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 16; i++)
         applyStimulus(15'(16384 + i), 16'(100 + i), 1'b1);
      checkOutput("full_level", {27'd0, fifo_level}, 32'd16);
      scr_ready = 1'b1;
      applyStimulus(15'(16384 + 50), 16'd777, 1'b1);
      checkOutput("pushpop_level", {27'd0, fifo_level}, 32'd16);
      checkOutput("pushpop_overflow", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("pp_data_%0d", i), {16'd0, scr_data},
                     (i == 15) ? 32'd777 : 32'(101 + i));
         tick();
      end
      checkOutput("pp_empty", {27'd0, fifo_level}, 32'd0);
      scr_ready = 1'b0;

      // Keyboard register
      kbd_code   = 16'd65;
      kbd_strobe = 1'b1;
      tick();
      kbd_strobe = 1'b0;
      readCheck("kbd_65", 15'd24576, 16'd65);
      applyStimulus(15'd24576, 16'd99, 1'b1);
      readCheck("kbd_cpu_write", 15'd24576, 16'd65);

      // Reset mid-operation, with a strobe on the reset edge
      for (int i = 0; i < 3; i++)
         applyStimulus(15'(16384 + i), 16'(200 + i), 1'b1);
      checkOutput("mid_level3", {27'd0, fifo_level}, 32'd3);
      reset      = 1'b0;
      kbd_code   = 16'd5;
      kbd_strobe = 1'b1;
      tick();
      reset      = 1'b1;
      kbd_strobe = 1'b0;
      checkOutput("mid_level0", {27'd0, fifo_level}, 32'd0);
      checkOutput("mid_valid0", {31'd0, scr_valid}, 32'd0);
      readCheck("mid_kbd0", 15'd24576, 16'd0);
      readCheck("mid_ram_kept", 15'd1000, 16'd12345);

      // Ready while empty must not disturb the level
      scr_ready = 1'b1;
      tick();
      scr_ready = 1'b0;
      checkOutput("empty_ready_level", {27'd0, fifo_level}, 32'd0);
      checkOutput("empty_ready_valid", {31'd0, scr_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
